wrr_packet_arbiter: RTL and testbench
=====================================

# wrr_packet_arbiter

Weighted round-robin arbiter with packet-level grant locking for the crossbar output ports. It generalises the single-cycle round-robin arbiter with grant holding in three ways: a parametrised requester count, a per-requester packet quantum (weight), and a grant that stays locked until end-of-packet under a downstream ready handshake. One instance sits at each crossbar output and selects which ingress port drives it.

## Interface
- P_WIDTH, 4: number of requesters (ingress ports), ≥2.
- P_WEIGHT_W, 4: width of each per-requester weight field.
- clk_i  input  1  single clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- request_i  input  P_WIDTH  per-requester valid; acts as beat valid while granted.
- last_i  input  P_WIDTH  per-requester end-of-packet flag, qualified by that requester's beat.
- ready_i  input  1  downstream accepts a beat this cycle.
- weight_i  input  P_WIDTH*P_WEIGHT_W  packets per turn, field i at [i*P_WEIGHT_W +: P_WEIGHT_W]; quasi-static.
- grant_o  output  P_WIDTH  registered one-hot grant, or all zero.
- grant_valid_o  output  1  registered, equals |grant_o.
- grant_idx_o  output  $clog2(P_WIDTH)  registered binary index of the granted requester; 0 when idle.

## Operation
- States: IDLE (no grant) and LOCKED (grant_o holds requester g).
- Beat accepted: LOCKED & request_i[g] & ready_i. The packet ends on an accepted beat with last_i[g]=1.
- in_pkt flag: set on an accepted beat with last=0; cleared on an accepted beat with last=1. The cycle with in_pkt=0 is a packet boundary.
- Credit: on grant, latch q = weight_i[g], with 0 treated as 1, and clear cnt. On each completed packet, cnt++.
- Release conditions, evaluated each LOCKED cycle:
  - (a) The completed packet makes cnt+1 == q.
  - (b) The state is at a packet boundary and request_i[g]=0.
- A mid-packet drop of request_i[g] does not release. It stalls with the grant held; there is no timeout.
- Pick: a priority search over request_i starting at ptr and wrapping modulo P_WIDTH. The first set bit wins.
- IDLE: if request_i is nonzero, pick and go to LOCKED. Otherwise stay in IDLE.
- Release: ptr <= g+1 (mod P_WIDTH). A pick is made in the same cycle using the new ptr, so the released requester has lowest priority but can win if it is the only requester. If no requester is active, go to IDLE.
- last_i and request_i for non-granted requesters are ignored.

## Timing
- Reset values: state IDLE, grant_o=0, grant_valid_o=0, grant_idx_o=0, ptr=0, cnt=0, in_pkt=0.
- Request to grant: 1 cycle. A request seen in cycle t gives grant_o in cycle t+1.
- Release to next grant: 0 bubble cycles. The grant changes on the edge after the releasing cycle, directly to the new winner.
- Single-beat packet: last_i=1 on the first beat. It counts as a complete packet and in_pkt stays 0.
- Simultaneous release and requests: the pick uses request_i of the releasing cycle.
- weight_i is sampled only at grant time. A change mid-turn takes effect on the next grant of that requester.
- Reset mid-packet: the grant drops in the next cycle with no drain. Upstream is responsible for discarding the partial packet.
- ready_i low freezes cnt and in_pkt. The grant is held.

## Structure
- Package arb_pkg holds:
  - arb_state_e enum {IDLE, LOCKED}.
  - Function eff_weight(w) mapping 0 to 1.
  - Index width localparam derived from P_WIDTH via $clog2.
- Sub-module rr_priority_pick: combinational, parameter P_WIDTH. Inputs req and ptr; outputs onehot, idx, any. It uses a doubled-vector search to avoid a cyclic carry chain. The arbiter instantiates it once.
- The top level holds the FSM, ptr, cnt (P_WEIGHT_W bits), q latch and in_pkt.

## Test plan
- Basic grant: reset, then request_i=4'b0110, all weights 1, single-beat packets, ready=1. Grants go 1,2,1,2…, each lasting one cycle after the first grant, with no bubbles.
- Weighting: weights {3,1,1,1}, all requesting, single-beat packets. The pattern repeats idx 0,0,0,1,2,3.
- Packet lock: requester 2 is granted and sends a 5-beat packet, with ready_i toggling 1,0,1,0…. requester 0 is also active. grant_o stays 4'b0100 until the beat with last=1 is accepted, then moves to 4'b0001 the next cycle.
- Drops: requester 1 drops its request mid-packet, so the grant is held. Requester 1 then drops its request at a boundary with q=3 and cnt=1, so release happens in that cycle and the next requester is granted.
- Weight-zero and wrap: weight_i[3]=0 and ptr=3. Requester 3 gets exactly 1 packet, then ptr wraps to 0.
- Reset mid-packet: assert rst_i during beat 2 of a packet. The next cycle shows all outputs 0 and state IDLE. After reset the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int MAX_WEIGHT_W    = 16;
  localparam int DEFAULT_P_WIDTH = 4;
  localparam int DEFAULT_IDX_W   = $clog2(DEFAULT_P_WIDTH);

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero weight still grants one packet per turn.
  function automatic logic [MAX_WEIGHT_W-1:0] eff_weight(input logic [MAX_WEIGHT_W-1:0] w);
    return (w == '0) ? MAX_WEIGHT_W'(1) : w;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr_i,
// wrapping modulo P_WIDTH.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int P_WIDTH = 4
) (
  input  logic [P_WIDTH-1:0]            req_i,
  input  logic [idx_width(P_WIDTH)-1:0] ptr_i,
  output logic [P_WIDTH-1:0]            onehot_o,
  output logic [idx_width(P_WIDTH)-1:0] idx_o,
  output logic                          any_o
);

  localparam int IDX_W = idx_width(P_WIDTH);

  logic [2*P_WIDTH-1:0] dbl_req;
  logic [2*P_WIDTH-1:0] rot_req;
  logic [P_WIDTH-1:0]   window;
  logic [IDX_W-1:0]     offset;
  logic                 found;
  logic [IDX_W:0]       sum;
  logic [IDX_W:0]       sum_wrapped;

  // Rotating the doubled vector turns the wrap-around search into a plain
  // lowest-set-bit search with no cyclic carry path.
  assign dbl_req = {req_i, req_i};
  assign rot_req = dbl_req >> ptr_i;
  assign window  = rot_req[P_WIDTH-1:0];

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int k = 0; k < P_WIDTH; k++) begin
      if (!found && window[k]) begin
        found  = 1'b1;
        offset = IDX_W'(k);
      end
    end
  end

  assign sum         = {1'b0, ptr_i} + {1'b0, offset};
  assign sum_wrapped = (sum >= (IDX_W+1)'(P_WIDTH)) ? (sum - (IDX_W+1)'(P_WIDTH)) : sum;
  assign any_o       = found;
  assign idx_o       = found ? sum_wrapped[IDX_W-1:0] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < P_WIDTH; gi++) begin : g_onehot
      assign onehot_o[gi] = found && (idx_o == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin arbiter that locks the grant for whole packets and
// gives each requester up to its weight in packets per turn.
module wrr_packet_arbiter
  import arb_pkg::*;
#(
  parameter int P_WIDTH    = 4,
  parameter int P_WEIGHT_W = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [P_WIDTH-1:0]              request_i,
  input  logic [P_WIDTH-1:0]              last_i,
  input  logic                            ready_i,
  input  logic [P_WIDTH*P_WEIGHT_W-1:0]   weight_i,
  output logic [P_WIDTH-1:0]              grant_o,
  output logic                            grant_valid_o,
  output logic [$clog2(P_WIDTH)-1:0]      grant_idx_o
);

  localparam int                IDX_W    = idx_width(P_WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(P_WIDTH - 1);

  arb_state_e          state_q;
  logic [P_WIDTH-1:0]  grant_q;
  logic                grant_valid_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [P_WEIGHT_W-1:0] cnt_q;
  logic [P_WEIGHT_W-1:0] quota_q;
  logic                in_pkt_q;

  logic                  locked;
  logic                  g_req;
  logic                  g_last;
  logic                  beat;
  logic                  pkt_done;
  logic [P_WEIGHT_W:0]   cnt_inc;
  logic                  rel_quota;
  logic                  rel_idle;
  logic                  release_now;
  logic [IDX_W-1:0]      ptr_after;
  logic [IDX_W-1:0]      pick_ptr;
  logic [P_WIDTH-1:0]    pick_onehot;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [P_WEIGHT_W-1:0] weight_arr [P_WIDTH];
  logic [P_WEIGHT_W-1:0] quota_new;
  logic                  load_grant;
  logic                  go_idle;

  genvar gi;
  generate
    for (gi = 0; gi < P_WIDTH; gi++) begin : g_weight
      assign weight_arr[gi] = weight_i[gi*P_WEIGHT_W +: P_WEIGHT_W];
    end
  endgenerate

  assign locked   = (state_q == LOCKED);
  assign g_req    = request_i[idx_q];
  assign g_last   = last_i[idx_q];
  assign beat     = locked && g_req && ready_i;
  assign pkt_done = beat && g_last;
  assign cnt_inc  = {1'b0, cnt_q} + (P_WEIGHT_W+1)'(1);

  // Release on quota exhaustion, or when the owner goes quiet between packets.
  assign rel_quota   = pkt_done && (cnt_inc == {1'b0, quota_q});
  assign rel_idle    = locked && !in_pkt_q && !g_req;
  assign release_now = rel_quota || rel_idle;

  assign ptr_after = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
  assign pick_ptr  = locked ? ptr_after : ptr_q;

  rr_priority_pick #(
    .P_WIDTH (P_WIDTH)
  ) u_pick (
    .req_i    (request_i),
    .ptr_i    (pick_ptr),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign quota_new  = P_WEIGHT_W'(eff_weight(MAX_WEIGHT_W'(weight_arr[pick_idx])));
  assign load_grant = pick_any && (!locked || release_now);
  assign go_idle    = release_now && !pick_any;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      idx_q         <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      quota_q       <= '0;
      in_pkt_q      <= 1'b0;
    end else begin
      if (release_now) begin
        ptr_q <= ptr_after;
      end
      if (load_grant) begin
        state_q       <= LOCKED;
        grant_q       <= pick_onehot;
        grant_valid_q <= 1'b1;
        idx_q         <= pick_idx;
        quota_q       <= quota_new;
        cnt_q         <= '0;
        in_pkt_q      <= 1'b0;
      end else if (go_idle) begin
        state_q       <= IDLE;
        grant_q       <= '0;
        grant_valid_q <= 1'b0;
        idx_q         <= '0;
        cnt_q         <= '0;
        in_pkt_q      <= 1'b0;
      end else if (beat) begin
        if (g_last) begin
          cnt_q    <= cnt_q + P_WEIGHT_W'(1);
          in_pkt_q <= 1'b0;
        end else begin
          in_pkt_q <= 1'b1;
        end
      end
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid_q;
  assign grant_idx_o   = idx_q;

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Scoreboard bench for wrr_packet_arbiter: directed scenarios plus random
// traffic, checked cycle by cycle against a packet-level reference model.
module tb_wrr_packet_arbiter;

  localparam int P  = 4;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [P-1:0]  req = '0;
  logic [P-1:0]  last = '0;
  logic          ready = 1'b0;
  logic [P*WW-1:0] weight = 16'h1111;
  logic [P*WW-1:0] w_cfg  = 16'h1111;
  logic [P-1:0]  grant;
  logic          gvalid;
  logic [1:0]    gidx;

  always #5 clk = ~clk;

  wrr_packet_arbiter #(
    .P_WIDTH    (P),
    .P_WEIGHT_W (WW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .request_i     (req),
    .last_i        (last),
    .ready_i       (ready),
    .weight_i      (weight),
    .grant_o       (grant),
    .grant_valid_o (gvalid),
    .grant_idx_o   (gidx)
  );

  typedef struct {
    logic [P-1:0] g;
    logic         v;
    logic [1:0]   idx;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: who owns the output, packets left in its turn,
  // whether a packet is open, and where the next search starts.
  bit m_locked = 0;
  int m_owner  = 0;
  int m_left   = 0;
  bit m_open   = 0;
  int m_start  = 0;

  function automatic int rr_pick(input logic [P-1:0] r, input int from);
    for (int k = 0; k < P; k++) begin
      int i;
      i = (from + k) % P;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic int eff_w(input int i);
    int w;
    w = int'(weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_step(input logic r_rst, input logic [P-1:0] r,
                            input logic [P-1:0] l, input logic rdy);
    bit done_turn;
    int win;
    if (r_rst) begin
      m_locked = 0; m_owner = 0; m_left = 0; m_open = 0; m_start = 0;
    end else if (!m_locked) begin
      win = rr_pick(r, m_start);
      if (win >= 0) begin
        m_locked = 1; m_owner = win; m_left = eff_w(win); m_open = 0;
      end
    end else begin
      done_turn = 0;
      if (r[m_owner] && rdy) begin
        if (l[m_owner]) begin
          m_left--;
          m_open = 0;
          if (m_left == 0) done_turn = 1;
        end else begin
          m_open = 1;
        end
      end else if (!m_open && !r[m_owner]) begin
        done_turn = 1;
      end
      if (done_turn) begin
        m_start = (m_owner + 1) % P;
        win = rr_pick(r, m_start);
        if (win >= 0) begin
          m_owner = win; m_left = eff_w(win); m_open = 0;
        end else begin
          m_locked = 0; m_owner = 0; m_open = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic r_rst, input logic [P-1:0] r,
                       input logic [P-1:0] l, input logic rdy);
    exp_t e;
    @(negedge clk);
    rst = r_rst; req = r; last = l; ready = rdy; weight = w_cfg;
    cyc++;
    model_step(r_rst, r, l, rdy);
    e.g   = m_locked ? (P'(1) << m_owner) : '0;
    e.v   = m_locked;
    e.idx = m_locked ? 2'(m_owner) : 2'd0;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    drive(1'b1, '0, '0, 1'b0);
    drive(1'b1, '0, '0, 1'b0);
  endtask

  // Monitor: one expected response per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.g || gvalid !== e.v || gidx !== e.idx) begin
          errors++;
          $display("FAIL grant cyc=%0d got grant=%b valid=%b idx=%0d expected grant=%b valid=%b idx=%0d",
                   e.cyc, grant, gvalid, gidx, e.g, e.v, e.idx);
        end else begin
          $display("cyc=%0d grant=%b valid=%b idx=%0d ok", e.cyc, grant, gvalid, gidx);
        end
      end
    end
  end

  initial begin
    int  acc;
    bit  tog;
    logic [P-1:0] r, l;

    // Basic alternation between requesters 1 and 2.
    w_cfg = 16'h1111;
    do_reset();
    repeat (8) drive(1'b0, 4'b0110, 4'b1111, 1'b1);

    // Weights {3,1,1,1}: pattern 0,0,0,1,2,3.
    w_cfg = 16'h1113;
    do_reset();
    repeat (14) drive(1'b0, 4'b1111, 4'b1111, 1'b1);

    // Packet lock: 5-beat packet from requester 2 with ready toggling.
    w_cfg = 16'h1111;
    do_reset();
    drive(1'b0, 4'b0100, 4'b0000, 1'b1);
    acc = 0; tog = 1;
    while (acc < 5) begin
      drive(1'b0, 4'b0101, (acc == 4) ? 4'b0100 : 4'b0000, tog);
      if (tog) acc++;
      tog = !tog;
    end
    repeat (3) drive(1'b0, 4'b0001, 4'b0001, 1'b1);

    // Drops: mid-packet drop holds, boundary drop releases (q=3, cnt=1).
    w_cfg = 16'h0030;
    do_reset();
    drive(1'b0, 4'b0010, 4'b0000, 1'b1);
    drive(1'b0, 4'b0010, 4'b0000, 1'b1);
    repeat (3) drive(1'b0, 4'b0000, 4'b0000, 1'b1);
    drive(1'b0, 4'b0010, 4'b0010, 1'b1);
    drive(1'b0, 4'b0100, 4'b0000, 1'b1);
    drive(1'b0, 4'b0100, 4'b0100, 1'b1);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1);

    // Weight zero on requester 3 with the pointer at 3, then wrap to 0.
    w_cfg = 16'h0111;
    do_reset();
    drive(1'b0, 4'b0100, 4'b0100, 1'b1);
    drive(1'b0, 4'b1101, 4'b1111, 1'b1);
    repeat (4) drive(1'b0, 4'b1001, 4'b1111, 1'b1);

    // Reset during beat 2 of a packet, then lowest requester wins.
    w_cfg = 16'h2222;
    do_reset();
    drive(1'b0, 4'b0001, 4'b0000, 1'b1);
    drive(1'b0, 4'b0001, 4'b0000, 1'b1);
    drive(1'b1, 4'b0001, 4'b0000, 1'b1);
    drive(1'b0, 4'b1010, 4'b0000, 1'b1);
    drive(1'b0, 4'b1010, 4'b0010, 1'b1);

    // Random traffic with occasional weight changes and resets.
    for (int n = 0; n < 1500; n++) begin
      if (n % 250 == 0) w_cfg = 16'($urandom);
      r = 4'($urandom) | (($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom));
      l = 4'($urandom);
      drive(($urandom_range(0, 199) == 0), r, l, ($urandom_range(0, 3) != 0));
    end

    drive(1'b0, 4'b0000, 4'b0000, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0 pending", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
